// File: rtl/ct_lsu_spsram_init_ctrl_if.sv
// Request/response and macro-pin bundle for the LSU single-port SRAM access controller.
// The master side is the requester plus the macro's read-data pin; the slave side is the controller.
interface ct_lsu_spsram_init_ctrl_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 54
);
   logic                  init_start;
   logic                  init_busy;
   logic                  init_done;
   logic                  req_vld;
   logic                  req_rdy;
   logic                  req_wen;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0] req_bwen;
   logic                  rdata_vld;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [ADDR_WIDTH-1:0] sram_a;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_q;

   modport master (
      output init_start, req_vld, req_wen, req_addr, req_wdata, req_bwen, sram_q,
      input  init_busy, init_done, req_rdy, rdata_vld, rdata,
             sram_cen, sram_gwen, sram_wen, sram_a, sram_d
   );

   modport slave (
      input  init_start, req_vld, req_wen, req_addr, req_wdata, req_bwen, sram_q,
      output init_busy, init_done, req_rdy, rdata_vld, rdata,
             sram_cen, sram_gwen, sram_wen, sram_a, sram_d
   );
endinterface

// File: rtl/ct_lsu_spsram_init_ctrl.sv
// Access controller in front of one LSU single-port SRAM macro: sweeps every entry to
// INIT_VALUE after reset or on request, otherwise passes one read or write per cycle.
module ct_lsu_spsram_init_ctrl #(
   parameter int                    ADDR_WIDTH = 9,
   parameter int                    DATA_WIDTH = 54,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
   input logic                        forever_cpuclk,
   input logic                        cpurst_b,
   ct_lsu_spsram_init_ctrl_if.slave   bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST = {ADDR_WIDTH{1'b1}};

   typedef enum logic [1:0] {RST, INIT, READY} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_nxt;
   logic                  rd_pend, rd_pend2;
   logic                  init_done_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  req_acc;
   logic                  rd_acc;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state    <= RST;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      init_cnt_nxt  = init_cnt;
      req_acc       = 1'b0;
      bus.req_rdy   = 1'b0;
      bus.init_busy = 1'b0;
      bus.sram_cen  = 1'b1;
      bus.sram_gwen = 1'b1;
      bus.sram_wen  = {DATA_WIDTH{1'b1}};
      bus.sram_a    = '0;
      bus.sram_d    = '0;
      case (state)
         RST: begin
            bus.init_busy = 1'b1;
            state_nxt     = INIT;
         end
         INIT: begin
            bus.init_busy = 1'b1;
            bus.sram_cen  = 1'b0;
            bus.sram_gwen = 1'b0;
            bus.sram_wen  = '0;
            bus.sram_a    = init_cnt;
            bus.sram_d    = INIT_VALUE;
            init_cnt_nxt  = init_cnt + ADDR_WIDTH'(1);
            if (init_cnt == LAST) state_nxt = READY;
         end
         READY: begin
            // A pending init request blocks acceptance so the sweep starts on a quiet macro.
            bus.req_rdy = ~bus.init_start;
            req_acc     = bus.req_vld & ~bus.init_start;
            if (req_acc) begin
               bus.sram_cen = 1'b0;
               bus.sram_a   = bus.req_addr;
               if (bus.req_wen) begin
                  bus.sram_gwen = 1'b0;
                  bus.sram_wen  = ~bus.req_bwen;
                  bus.sram_d    = bus.req_wdata;
               end
            end
            if (bus.init_start) begin
               state_nxt    = INIT;
               init_cnt_nxt = '0;
            end
         end
         default: state_nxt = RST;
      endcase
   end

   assign rd_acc = req_acc & ~bus.req_wen;

   // Macro returns data one cycle after the read; capture it then, flag it a cycle later.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_pend     <= 1'b0;
         rd_pend2    <= 1'b0;
         rdata_q     <= '0;
         init_done_q <= 1'b0;
      end else begin
         rd_pend     <= rd_acc;
         rd_pend2    <= rd_pend;
         init_done_q <= (state == INIT) && (init_cnt == LAST);
         if (rd_pend) rdata_q <= bus.sram_q;
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.rdata_vld = rd_pend2;
   assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_ct_lsu_spsram_init_ctrl.sv
// Bench for ct_lsu_spsram_init_ctrl: behavioural macro, array reference model and
// read-return scoreboard, with directed and randomized accesses around init sweeps and resets.
module tb_ct_lsu_spsram_init_ctrl;
   localparam int AW    = 9;
   localparam int DW    = 54;
   localparam int DEPTH = 1 << AW;
   localparam int PW    = 2 * DW + AW + 2;
   localparam logic [DW-1:0] INITV = '0;
   localparam logic [PW-1:0] IDLE  = {1'b1, 1'b1, {DW{1'b1}}, {AW{1'b0}}, {DW{1'b0}}};

   logic clk = 1'b0;
   logic rst_n;
   logic fill;
   always #5 clk = ~clk;

   ct_lsu_spsram_init_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ct_lsu_spsram_init_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(INITV)) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .bus            (bus)
   );

   // Macro: bit-masked write, read data registered one cycle after the read edge.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DW'({$urandom(), $urandom()});
      end else if (!bus.sram_cen) begin
         if (!bus.sram_gwen)
            mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
         else
            bus.sram_q <= mem[bus.sram_a];
      end
   end

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rd_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   rd_t           rq[$];
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_rdata;
   logic          done_exp;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] pins_now();
      return {bus.sram_cen, bus.sram_gwen, bus.sram_wen, bus.sram_a, bus.sram_d};
   endfunction

   task automatic set_req(logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                          logic [DW-1:0] be, logic st);
      bus.req_vld    = v;
      bus.req_wen    = w;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_bwen   = be;
      bus.init_start = st;
   endtask

   // Advance one cycle and check the read-return port against the scoreboard.
   task automatic tick();
      logic ev;
      @(posedge clk);
      #1;
      cyc++;
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      if (ev) begin
         exp_rdata = rq[0].data;
         void'(rq.pop_front());
      end
      chk("rdata", 128'({bus.rdata_vld, bus.rdata}), 128'({ev, exp_rdata}));
   endtask

   // One READY-phase cycle.
   task automatic op(logic v, logic w, logic [AW-1:0] a, logic [DW-1:0] d,
                     logic [DW-1:0] be, logic st);
      logic          acc;
      logic [PW-1:0] pexp;
      rd_t           e;
      set_req(v, w, a, d, be, st);
      #1;
      acc = v && !st;
      chk("req_rdy", 128'(bus.req_rdy), 128'(!st));
      chk("busy_done", 128'({bus.init_busy, bus.init_done}), 128'({1'b0, done_exp}));
      done_exp = 1'b0;
      if (acc && w)  pexp = {1'b0, 1'b0, ~be, a, d};
      else if (acc)  pexp = {1'b0, 1'b1, {DW{1'b1}}, a, {DW{1'b0}}};
      else           pexp = IDLE;
      chk("pins", 128'(pins_now()), 128'(pexp));
      if (acc && w) begin
         ref_mem[a] = (ref_mem[a] & ~be) | (d & be);
      end else if (acc) begin
         e.due  = cyc + 2;
         e.data = ref_mem[a];
         rq.push_back(e);
      end
      tick();
   endtask

   // n init cycles with random noise on the request port (never accepted, init_start ignored).
   task automatic sweep(int n);
      for (int i = 0; i < n; i++) begin
         set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom()),
                 DW'({$urandom(), $urandom()}), '1, 1'($urandom_range(0, 1)));
         #1;
         chk("sweep", 128'({pins_now(), bus.init_busy, bus.init_done, bus.req_rdy}),
             128'({1'b0, 1'b0, {DW{1'b0}}, AW'(i), INITV, 1'b1, 1'b0, 1'b0}));
         tick();
      end
      set_req(0, 0, '0, '0, '0, 0);
      if (n == DEPTH) begin
         done_exp = 1'b1;
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = INITV;
      end
   endtask

   // Assert reset now, hold it for `hold` cycles, release and step through the RST cycle.
   task automatic do_reset(int hold);
      rst_n     = 1'b0;
      rq.delete();
      exp_rdata = '0;
      done_exp  = 1'b0;
      set_req(0, 0, '0, '0, '0, 0);
      #1;
      chk("rst_now", 128'({pins_now(), bus.init_busy, bus.init_done, bus.req_rdy,
                           bus.rdata_vld, bus.rdata}),
          128'({IDLE, 1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}));
      repeat (hold) begin
         tick();
         chk("rst_hold", 128'({pins_now(), bus.init_busy, bus.init_done, bus.req_rdy}),
             128'({IDLE, 1'b1, 1'b0, 1'b0}));
      end
      rst_n = 1'b1;
      #1;
      chk("rst_cycle", 128'({pins_now(), bus.init_busy, bus.req_rdy}),
          128'({IDLE, 1'b1, 1'b0}));
      tick();
   endtask

   logic [AW-1:0] ra;
   logic [DW-1:0] rdv, rbe;
   logic [DW-1:0] v0, v1, v2;

   initial begin
      rst_n     = 1'b0;
      fill      = 1'b1;
      exp_rdata = '0;
      done_exp  = 1'b0;
      set_req(0, 0, '0, '0, '0, 0);
      tick();
      fill = 1'b0;

      // Power-up: RST cycle then full sweep, request held throughout.
      do_reset(2);
      sweep(DEPTH);

      // Full write then read back.
      op(1, 1, 9'h1A5, 54'h2A_BCDE_F012_3456, '1, 0);
      op(1, 0, 9'h1A5, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);

      // Partial write over an initialised entry, and a write with no bits enabled.
      op(1, 1, 9'h010, '1, 54'hFF, 0);
      op(1, 1, 9'h011, 54'h15_5555_5555_5555, '0, 0);
      op(1, 0, 9'h010, '0, '0, 0);
      op(1, 0, 9'h011, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);

      // Back-to-back reads.
      v0 = DW'({$urandom(), $urandom()});
      v1 = DW'({$urandom(), $urandom()});
      v2 = DW'({$urandom(), $urandom()});
      op(1, 1, 9'd0, v0, '1, 0);
      op(1, 1, 9'd1, v1, '1, 0);
      op(1, 1, 9'd2, v2, '1, 0);
      op(1, 0, 9'd0, '0, '0, 0);
      op(1, 0, 9'd1, '0, '0, 0);
      op(1, 0, 9'd2, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);

      // Randomized traffic concentrated on a few addresses.
      for (int k = 0; k < 300; k++) begin
         ra  = ($urandom_range(0, 3) == 0) ? AW'($urandom()) : AW'($urandom_range(0, 15));
         rdv = DW'({$urandom(), $urandom()});
         rbe = ($urandom_range(0, 1) == 1) ? '1 : DW'({$urandom(), $urandom()});
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rdv, rbe, 0);
      end

      // Read the cycle before init_start; requester also asserting req_vld with init_start.
      op(1, 0, 9'd1, '0, '0, 0);
      op(1, 0, 9'd2, '0, '0, 1);
      sweep(DEPTH);
      op(1, 0, 9'd1, '0, '0, 0);
      op(1, 1, 9'd3, v2, '1, 0);
      op(0, 0, '0, '0, '0, 0);

      // Reset in the middle of a sweep.
      op(0, 0, '0, '0, '0, 1);
      sweep(200);
      do_reset(3);
      sweep(DEPTH);
      op(1, 0, 9'd3, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);

      // Reset while a read is in flight drops its return.
      op(1, 1, 9'd4, v1, '1, 0);
      op(1, 0, 9'd4, '0, '0, 0);
      do_reset(3);
      sweep(DEPTH);
      op(1, 0, 9'd4, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);
      op(0, 0, '0, '0, '0, 0);
      chk("rq_drained", 128'(rq.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
